// File: rtl/disp_sched.sv
// Display-content scheduler: arbitrates keypad entry, timed messages and alarm
// onto one 4-digit hex display word, with ms-tick based message hold and blink.
module disp_sched #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned MSG_MS     = 2000,
    parameter int unsigned BLINK_MS   = 500,
    parameter logic [15:0] ALARM_CODE = 16'hEEEE
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        entry_valid,
    input  logic [15:0] entry_data,
    input  logic        msg_req,
    input  logic [15:0] msg_data,
    input  logic        alarm,
    output logic        msg_ack,
    output logic [15:0] disp_data,
    output logic        disp_en,
    output logic [1:0]  state
);

    localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
    localparam logic [11:0] MSG_LAST   = 12'(MSG_MS - 1);
    localparam logic [11:0] BLINK_LAST = 12'(BLINK_MS - 1);
    localparam logic [15:0] BLANK_CODE = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_BLANK = 2'd0,
        ST_ENTRY = 2'd1,
        ST_MSG   = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_tick_cnt;
    logic [11:0] r_ms_cnt;
    logic [15:0] r_msg_word;
    logic        r_req_blk;
    logic        r_msg_ack;
    logic [15:0] r_disp_data;
    logic        r_disp_en;

    logic        w_tick;
    logic        w_accept;
    state_t      w_idle_state;
    logic [15:0] w_idle_data;

    assign w_tick       = (r_tick_cnt == TICK_LAST);
    // r_req_blk holds off a request that was already acked until it is seen low
    assign w_accept     = msg_req && !r_req_blk;
    assign w_idle_state = entry_valid ? ST_ENTRY : ST_BLANK;
    assign w_idle_data  = entry_valid ? entry_data : BLANK_CODE;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state     <= ST_BLANK;
            r_tick_cnt  <= '0;
            r_ms_cnt    <= '0;
            r_msg_word  <= '0;
            r_req_blk   <= 1'b0;
            r_msg_ack   <= 1'b0;
            r_disp_data <= BLANK_CODE;
            r_disp_en   <= 1'b0;
        end else begin
            r_msg_ack <= 1'b0;
            if (!msg_req)
                r_req_blk <= 1'b0;
            unique case (r_state)
                ST_BLANK, ST_ENTRY: begin
                    r_tick_cnt <= '0;
                    r_ms_cnt   <= '0;
                    if (alarm) begin
                        r_state     <= ST_ALARM;
                        r_disp_data <= ALARM_CODE;
                        r_disp_en   <= 1'b1;
                    end else if (w_accept) begin
                        r_state     <= ST_MSG;
                        r_msg_word  <= msg_data;
                        r_disp_data <= msg_data;
                        r_disp_en   <= 1'b1;
                        r_msg_ack   <= 1'b1;
                        r_req_blk   <= 1'b1;
                    end else begin
                        r_state     <= w_idle_state;
                        r_disp_data <= w_idle_data;
                        r_disp_en   <= entry_valid;
                    end
                end
                ST_MSG: begin
                    if (alarm) begin
                        r_state     <= ST_ALARM;
                        r_disp_data <= ALARM_CODE;
                        r_disp_en   <= 1'b1;
                        r_tick_cnt  <= '0;
                        r_ms_cnt    <= '0;
                    end else if (w_tick) begin
                        r_tick_cnt <= '0;
                        if (r_ms_cnt == MSG_LAST) begin
                            r_ms_cnt    <= '0;
                            r_state     <= w_idle_state;
                            r_disp_data <= w_idle_data;
                            r_disp_en   <= entry_valid;
                        end else begin
                            r_ms_cnt    <= r_ms_cnt + 12'd1;
                            r_disp_data <= r_msg_word;
                        end
                    end else begin
                        r_tick_cnt  <= r_tick_cnt + 16'd1;
                        r_disp_data <= r_msg_word;
                    end
                end
                ST_ALARM: begin
                    if (!alarm) begin
                        r_state     <= w_idle_state;
                        r_disp_data <= w_idle_data;
                        r_disp_en   <= entry_valid;
                        r_tick_cnt  <= '0;
                        r_ms_cnt    <= '0;
                    end else if (w_tick) begin
                        r_tick_cnt <= '0;
                        if (r_ms_cnt == BLINK_LAST) begin
                            r_ms_cnt  <= '0;
                            r_disp_en <= ~r_disp_en;
                        end else begin
                            r_ms_cnt <= r_ms_cnt + 12'd1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign msg_ack   = r_msg_ack;
    assign disp_data = r_disp_data;
    assign disp_en   = r_disp_en;
    assign state     = r_state;

endmodule

// File: tb/tb_disp_sched.sv
// Bench for disp_sched: directed scenarios plus a randomized run against an
// elapsed-time reference model of the display scheduler.
module tb_disp_sched;

    localparam int TICK_DIV = 4;
    localparam int MSG_MS   = 3;
    localparam int BLINK_MS = 2;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        entry_valid = 1'b0;
    logic [15:0] entry_data = '0;
    logic        msg_req = 1'b0;
    logic [15:0] msg_data = '0;
    logic        alarm = 1'b0;
    logic        msg_ack;
    logic [15:0] disp_data;
    logic        disp_en;
    logic [1:0]  state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    disp_sched #(
        .TICK_DIV  (TICK_DIV),
        .MSG_MS    (MSG_MS),
        .BLINK_MS  (BLINK_MS),
        .ALARM_CODE(16'hEEEE)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .entry_valid(entry_valid),
        .entry_data (entry_data),
        .msg_req    (msg_req),
        .msg_data   (msg_data),
        .alarm      (alarm),
        .msg_ack    (msg_ack),
        .disp_data  (disp_data),
        .disp_en    (disp_en),
        .state      (state)
    );

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        entry_valid = 1'b0;
        entry_data  = '0;
        msg_req     = 1'b0;
        msg_data    = '0;
        alarm       = 1'b0;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        #2;
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        entry_valid = 1'b1;
        entry_data  = 16'h9999;
        cyc();
        cyc();
        #2;
        Rst_n = 1'b0;
        #1;
        n_checks++; if (state !== 2'd0) $display("FAIL reset_state got %0d exp 0", state); else n_pass++;
        n_checks++; if (disp_data !== 16'hFFFF) $display("FAIL reset_data got %h exp ffff", disp_data); else n_pass++;
        n_checks++; if (disp_en !== 1'b0) $display("FAIL reset_en got %b exp 0", disp_en); else n_pass++;
        n_checks++; if (msg_ack !== 1'b0) $display("FAIL reset_ack got %b exp 0", msg_ack); else n_pass++;
        entry_valid = 1'b0;
        #1;
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (state !== 2'd0 || disp_en !== 1'b0 || disp_data !== 16'hFFFF)
                $display("FAIL idle_blank got st=%0d en=%b d=%h exp st=0 en=0 d=ffff", state, disp_en, disp_data);
            else n_pass++;
        end
    endtask

    task automatic test_entry();
        clear_inputs();
        do_reset();
        entry_valid = 1'b1;
        entry_data  = 16'h1234;
        cyc();
        n_checks++;
        if (state !== 2'd1 || disp_en !== 1'b1 || disp_data !== 16'h1234)
            $display("FAIL entry_1234 got st=%0d en=%b d=%h exp st=1 en=1 d=1234", state, disp_en, disp_data);
        else n_pass++;
        entry_data = 16'h5678;
        cyc();
        n_checks++; if (disp_data !== 16'h5678) $display("FAIL entry_5678 got %h exp 5678", disp_data); else n_pass++;
        entry_valid = 1'b0;
        cyc();
        n_checks++;
        if (state !== 2'd0 || disp_en !== 1'b0 || disp_data !== 16'hFFFF)
            $display("FAIL entry_release got st=%0d en=%b d=%h exp st=0 en=0 d=ffff", state, disp_en, disp_data);
        else n_pass++;
    endtask

    task automatic test_msg();
        clear_inputs();
        do_reset();
        entry_valid = 1'b1;
        entry_data  = 16'h1234;
        cyc();
        msg_req  = 1'b1;
        msg_data = 16'h0A1B;
        cyc();
        n_checks++;
        if (state !== 2'd2 || msg_ack !== 1'b1 || disp_data !== 16'h0A1B)
            $display("FAIL msg_accept got st=%0d ack=%b d=%h exp st=2 ack=1 d=0a1b", state, msg_ack, disp_data);
        else n_pass++;
        for (int k = 2; k <= 12; k++) begin
            cyc();
            n_checks++;
            if (state !== 2'd2 || msg_ack !== 1'b0 || disp_data !== 16'h0A1B)
                $display("FAIL msg_hold_c%0d got st=%0d ack=%b d=%h exp st=2 ack=0 d=0a1b", k, state, msg_ack, disp_data);
            else n_pass++;
        end
        cyc();
        n_checks++;
        if (state !== 2'd1 || msg_ack !== 1'b0 || disp_data !== 16'h1234)
            $display("FAIL msg_exit got st=%0d ack=%b d=%h exp st=1 ack=0 d=1234", state, msg_ack, disp_data);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (state !== 2'd1 || msg_ack !== 1'b0)
                $display("FAIL msg_no_reack got st=%0d ack=%b exp st=1 ack=0", state, msg_ack);
            else n_pass++;
        end
        msg_req = 1'b0;
        cyc();
    endtask

    task automatic test_alarm();
        logic exp_en;
        clear_inputs();
        do_reset();
        msg_req  = 1'b1;
        msg_data = 16'h0A1B;
        cyc();
        n_checks++; if (msg_ack !== 1'b1) $display("FAIL alarm_pre_ack got %b exp 1", msg_ack); else n_pass++;
        msg_req = 1'b0;
        cyc();
        cyc();
        alarm = 1'b1;
        cyc();
        n_checks++;
        if (state !== 2'd3 || disp_data !== 16'hEEEE || disp_en !== 1'b1 || msg_ack !== 1'b0)
            $display("FAIL alarm_enter got st=%0d d=%h en=%b ack=%b exp st=3 d=eeee en=1 ack=0", state, disp_data, disp_en, msg_ack);
        else n_pass++;
        for (int k = 1; k < 24; k++) begin
            cyc();
            exp_en = (k < 8) || (k >= 16);
            n_checks++;
            if (state !== 2'd3 || disp_data !== 16'hEEEE || disp_en !== exp_en)
                $display("FAIL alarm_blink_c%0d got st=%0d d=%h en=%b exp st=3 d=eeee en=%b", k, state, disp_data, disp_en, exp_en);
            else n_pass++;
        end
        alarm = 1'b0;
        cyc();
        n_checks++;
        if (state !== 2'd0 || disp_data !== 16'hFFFF || disp_en !== 1'b0)
            $display("FAIL alarm_exit got st=%0d d=%h en=%b exp st=0 d=ffff en=0", state, disp_data, disp_en);
        else n_pass++;
        for (int k = 0; k < 14; k++) begin
            cyc();
            n_checks++;
            if (state !== 2'd0 || msg_ack !== 1'b0)
                $display("FAIL alarm_no_resume got st=%0d ack=%b exp st=0 ack=0", state, msg_ack);
            else n_pass++;
        end
    endtask

    task automatic test_contention();
        clear_inputs();
        do_reset();
        alarm    = 1'b1;
        msg_req  = 1'b1;
        msg_data = 16'hAAAA;
        cyc();
        n_checks++;
        if (state !== 2'd3 || msg_ack !== 1'b0)
            $display("FAIL cont_alarm_wins got st=%0d ack=%b exp st=3 ack=0", state, msg_ack);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++; if (msg_ack !== 1'b0) $display("FAIL cont_no_ack_alarm got %b exp 0", msg_ack); else n_pass++;
        end
        alarm = 1'b0;
        cyc();
        n_checks++;
        if (state !== 2'd0 || msg_ack !== 1'b0)
            $display("FAIL cont_alarm_exit got st=%0d ack=%b exp st=0 ack=0", state, msg_ack);
        else n_pass++;
        cyc();
        n_checks++;
        if (state !== 2'd2 || msg_ack !== 1'b1 || disp_data !== 16'hAAAA)
            $display("FAIL cont_late_accept got st=%0d ack=%b d=%h exp st=2 ack=1 d=aaaa", state, msg_ack, disp_data);
        else n_pass++;
        msg_req  = 1'b0;
        msg_data = '0;
        for (int k = 2; k <= 12; k++) begin
            if (k == 6) begin
                msg_req  = 1'b1;
                msg_data = 16'hC0DE;
            end
            cyc();
            n_checks++;
            if (state !== 2'd2 || msg_ack !== 1'b0 || disp_data !== 16'hAAAA)
                $display("FAIL cont_hold_c%0d got st=%0d ack=%b d=%h exp st=2 ack=0 d=aaaa", k, state, msg_ack, disp_data);
            else n_pass++;
        end
        cyc();
        n_checks++;
        if (state !== 2'd0 || msg_ack !== 1'b0)
            $display("FAIL cont_exit_first got st=%0d ack=%b exp st=0 ack=0", state, msg_ack);
        else n_pass++;
        cyc();
        n_checks++;
        if (state !== 2'd2 || msg_ack !== 1'b1 || disp_data !== 16'hC0DE)
            $display("FAIL cont_second_accept got st=%0d ack=%b d=%h exp st=2 ack=1 d=c0de", state, msg_ack, disp_data);
        else n_pass++;
        msg_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        do_reset();
        msg_req  = 1'b1;
        msg_data = 16'h1111;
        cyc();
        n_checks++; if (msg_ack !== 1'b1) $display("FAIL rmid_first_ack got %b exp 1", msg_ack); else n_pass++;
        for (int k = 2; k <= 5; k++) cyc();
        #2;
        Rst_n = 1'b0;
        #1;
        n_checks++;
        if (state !== 2'd0 || disp_data !== 16'hFFFF || disp_en !== 1'b0 || msg_ack !== 1'b0)
            $display("FAIL rmid_reset got st=%0d d=%h en=%b ack=%b exp st=0 d=ffff en=0 ack=0", state, disp_data, disp_en, msg_ack);
        else n_pass++;
        msg_data = 16'h2222;
        #1;
        Rst_n = 1'b1;
        cyc();
        n_checks++;
        if (state !== 2'd2 || msg_ack !== 1'b1 || disp_data !== 16'h2222)
            $display("FAIL rmid_reaccept got st=%0d ack=%b d=%h exp st=2 ack=1 d=2222", state, msg_ack, disp_data);
        else n_pass++;
        msg_req = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            cyc();
            n_checks++;
            if (state !== 2'd2 || msg_ack !== 1'b0)
                $display("FAIL rmid_hold_c%0d got st=%0d ack=%b exp st=2 ack=0", k, state, msg_ack);
            else n_pass++;
        end
        cyc();
        n_checks++; if (state !== 2'd0) $display("FAIL rmid_exit got st=%0d exp 0", state); else n_pass++;
    endtask

    // Reference: current mode plus cycles elapsed in it; hold and blink derive from elapsed time.
    task automatic test_random(input int ncyc);
        int          mode, nmode, n;
        int          hold_len, blink_len;
        logic        blk, acc, acked, exp_en;
        logic [15:0] word, exp_data;
        hold_len  = MSG_MS * TICK_DIV;
        blink_len = BLINK_MS * TICK_DIV;
        clear_inputs();
        do_reset();
        mode = 0; n = 0; blk = 1'b0; word = '0; acked = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if ($urandom_range(0, 19) == 0) entry_valid = ~entry_valid;
            if ($urandom_range(0, 2) == 0) entry_data = 16'($urandom);
            if (alarm) begin
                if ($urandom_range(0, 39) == 0) alarm = 1'b0;
            end else if ($urandom_range(0, 99) == 0) alarm = 1'b1;
            if (msg_ack) acked = 1'b1;
            if (!msg_req) begin
                if ($urandom_range(0, 14) == 0) begin
                    msg_req = 1'b1;
                    acked   = 1'b0;
                end
            end else if (acked && $urandom_range(0, 1) == 0) msg_req = 1'b0;
            else if (!acked && $urandom_range(0, 199) == 0) msg_req = 1'b0;
            msg_data = 16'($urandom);

            acc = 1'b0;
            case (mode)
                0, 1: begin
                    if (alarm) nmode = 3;
                    else if (msg_req && !blk) begin nmode = 2; acc = 1'b1; end
                    else nmode = entry_valid ? 1 : 0;
                end
                2: begin
                    if (alarm) nmode = 3;
                    else if (n + 1 == hold_len) nmode = entry_valid ? 1 : 0;
                    else nmode = 2;
                end
                default: nmode = alarm ? 3 : (entry_valid ? 1 : 0);
            endcase
            if (acc) begin word = msg_data; blk = 1'b1; end
            else if (!msg_req) blk = 1'b0;
            n    = (nmode == mode) ? n + 1 : 0;
            mode = nmode;
            case (mode)
                0:       begin exp_data = 16'hFFFF;   exp_en = 1'b0; end
                1:       begin exp_data = entry_data; exp_en = 1'b1; end
                2:       begin exp_data = word;       exp_en = 1'b1; end
                default: begin exp_data = 16'hEEEE;   exp_en = ((n / blink_len) % 2) == 0; end
            endcase

            cyc();
            n_checks++; if (state !== 2'(mode)) $display("FAIL rnd_state i=%0d got %0d exp %0d", i, state, mode); else n_pass++;
            n_checks++; if (disp_data !== exp_data) $display("FAIL rnd_data i=%0d got %h exp %h", i, disp_data, exp_data); else n_pass++;
            n_checks++; if (disp_en !== exp_en) $display("FAIL rnd_en i=%0d got %b exp %b", i, disp_en, exp_en); else n_pass++;
            n_checks++; if (msg_ack !== acc) $display("FAIL rnd_ack i=%0d got %b exp %b", i, msg_ack, acc); else n_pass++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_entry();
        test_msg();
        test_alarm();
        test_contention();
        test_reset_mid();
        test_random(3000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
Display-content scheduler for the lock's 4-digit seven-segment path. It shares one display between three requesters: live keypad entry, timed status messages, and an alarm indication. It selects a winner, times messages and alarm blinking from a millisecond tick, and drives the 16-bit hex word and enable consumed by the segment decoder/scanner. All outputs are registered. The downstream decoder renders nibble F as blank.

Parameters:
TICK_DIV, 50000, Clk cycles per ms tick (50 MHz -> 1 ms); tick counter 16 bits, legal values 2..65535
MSG_MS, 2000, message hold time in ticks; counter 12 bits, legal values 1..4095
BLINK_MS, 500, alarm blink half-period in ticks; legal values 1..4095
ALARM_CODE, 16'hEEEE, word shown during alarm

Ports:
Clk  in  1  system clock, 50 MHz
Rst_n  in  1  reset, asynchronous, active-low
entry_valid  in  1  level; keypad entry present
entry_data  in  16  keypad digits, nibble per digit
msg_req  in  1  message request; held high until msg_ack
msg_data  in  16  message word; valid while msg_req is high
alarm  in  1  level; alarm active
msg_ack  out  1  one-cycle pulse; message accepted
disp_data  out  16  word to the segment decoder
disp_en  out  1  display enable to the segment decoder
state  out  2  0 BLANK, 1 ENTRY, 2 MSG, 3 ALARM

Behaviour:
- Reset is async and active-low. Reset values: state=BLANK, disp_data=16'hFFFF, disp_en=0, msg_ack=0. The tick counter, ms counter and message latch all clear.
- Tick: tick_cnt counts 0..TICK_DIV-1. A 1-cycle tick pulse fires when tick_cnt = TICK_DIV-1. tick_cnt and ms_cnt clear on every state transition.
- Priority: ALARM > MSG > ENTRY > BLANK. Every transition is evaluated on each Clk edge, and outputs reflect the new state on that same edge. Input-to-output latency is 1 cycle.
- BLANK: disp_en=0, disp_data=FFFF.
  - alarm -> ALARM.
  - else msg_req -> MSG (accept).
  - else entry_valid -> ENTRY.
- ENTRY: disp_en=1, disp_data=entry_data, re-registered every cycle.
  - alarm -> ALARM.
  - else msg_req -> MSG (accept).
  - else !entry_valid -> BLANK.
- Accept: latch msg_data, pulse msg_ack for exactly the first cycle in MSG.
  - Only one ack per request. A req still high after the ack has been issued is not re-accepted until it has been seen low for at least one cycle.
- MSG: disp_en=1, disp_data=latched word. ms_cnt increments on each tick.
  - On the tick where ms_cnt = MSG_MS-1, exit to ENTRY if entry_valid, else BLANK.
  - Message display therefore lasts exactly MSG_MS*TICK_DIV cycles.
  - A new msg_req during MSG is not acked; it is accepted on the cycle after exit if still high.
  - alarm -> ALARM immediately. The message is discarded and not resumed.
- ALARM: disp_data=ALARM_CODE. disp_en=1 on entry, then toggles every BLINK_MS ticks (ms_cnt wraps at BLINK_MS-1).
  - msg_req is never acked in ALARM.
  - !alarm -> ENTRY if entry_valid, else BLANK. Blink phase is not retained.
- Simultaneous events:
  - alarm and msg_req in the same cycle: ALARM wins, no ack.
  - Exit of MSG coincident with a new req: exit first; the new request is accepted the following cycle.
- Reset mid-operation: immediate return to reset values. A pending request must be re-presented.
- entry_data and msg_data are not checked. Any nibble passes through unchanged.

Test Plan:
All scenarios use TICK_DIV=4, MSG_MS=3, BLINK_MS=2.
1. Reset and idle:
   - Assert Rst_n=0 mid-cycle -> disp_en=0, disp_data=FFFF, msg_ack=0, state=0 asynchronously.
   - Release with all inputs low -> stays BLANK.
2. Entry passthrough:
   - entry_valid=1, entry_data=16'h1234 -> next edge state=1, disp_en=1, disp_data=1234.
   - Change entry_data to 16'h5678 -> reflected 1 cycle later.
   - entry_valid=0 -> BLANK, FFFF.
3. Timed message:
   - In ENTRY (1234), msg_req=1 with msg_data=16'h0A1B.
   - Next edge: msg_ack=1 for 1 cycle, disp_data=0A1B.
   - Requester drops req after ack.
   - After exactly 12 cycles in MSG -> ENTRY, disp_data=1234.
   - Holding req high past the ack -> no second ack.
4. Alarm preemption and blink:
   - During MSG, alarm=1 -> next edge state=3, disp_data=EEEE, disp_en=1.
   - disp_en toggles every 8 cycles (1 for 8, 0 for 8, ...).
   - alarm=0 with entry_valid=0 -> BLANK; message not redisplayed.
5. Contention:
   - alarm=1 and msg_req=1 in the same cycle -> ALARM, msg_ack stays 0.
   - Second req (16'hC0DE) raised during MSG -> acked on the cycle after the first message ends.
6. Reset mid-message:
   - Rst_n low at MSG cycle 5 -> reset values immediately.
   - After release with msg_req still high -> fresh accept with a new ack and a full 12-cycle hold.
